// File: rtl/adv7513_reg_dump_if.sv
// Bundles the two handshakes of the register dump sequencer:
//   read request   : rd_start/rd_addr out, rd_done/rd_data back from the ADV7513 read block
//   output stream  : out_valid/out_addr/out_data/out_last/out_err out, out_ready back
// master = the dump sequencer, slave = the read block plus the downstream logger.
interface adv7513_reg_dump_if;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;

    modport master (
        output rd_start, rd_addr, out_valid, out_addr, out_data, out_last, out_err,
        input  rd_done, rd_data, out_ready
    );

    modport slave (
        input  rd_start, rd_addr, out_valid, out_addr, out_data, out_last, out_err,
        output rd_done, rd_data, out_ready
    );
endinterface

// File: rtl/adv7513_reg_dump.sv
// Walks registers FIRST_ADDR..LAST_ADDR, issuing one single-register read per
// address and streaming each (address, data) pair to a downstream logger.
// Every read is guarded by a timeout; a timeout emits one error beat and ends
// the dump.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   trigger        start a dump (only looked at while idle)
//   busy           high whenever a dump is in progress
//   bus            read-request and output-stream handshakes (master side)
//   dump_done      one-cycle pulse after the final beat is accepted
//   timeout_err    sticky timeout flag, cleared by the next accepted trigger
module adv7513_reg_dump #(
    parameter logic [7:0]  FIRST_ADDR     = 8'h00,
    parameter logic [7:0]  LAST_ADDR      = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trigger,
    output logic                      busy,
    adv7513_reg_dump_if.master        bus,
    output logic                      dump_done,
    output logic                      timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // DONE is the single cycle carrying dump_done, so busy drops the cycle after it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [7:0]    addr;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit_c;

    // The counter is 0 in the first WAIT cycle, so hitting TIMEOUT_CYCLES-1 here
    // means TIMEOUT_CYCLES cycles have elapsed since rd_start.
    assign tmo_hit_c = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Sequencer: state, address walk, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr          <= FIRST_ADDR;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            bus.rd_start  <= 1'b0;
            bus.rd_addr   <= 8'h00;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= 8'h00;
            bus.out_data  <= 8'h00;
            bus.out_last  <= 1'b0;
            bus.out_err   <= 1'b0;
            dump_done     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            bus.rd_start <= 1'b0;
            dump_done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        addr         <= FIRST_ADDR;
                        bus.rd_addr  <= FIRST_ADDR;
                        bus.rd_start <= 1'b1;
                        timeout_err  <= 1'b0;
                    end
                end

                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end

                // rd_done has priority over a timeout landing in the same cycle.
                WAIT: begin
                    if (bus.rd_done) begin
                        bus.out_valid <= 1'b1;
                        bus.out_addr  <= addr;
                        bus.out_data  <= bus.rd_data;
                        bus.out_last  <= (addr == LAST_ADDR);
                        bus.out_err   <= 1'b0;
                        state         <= EMIT;
                    end else if (tmo_hit_c) begin
                        bus.out_valid <= 1'b1;
                        bus.out_addr  <= addr;
                        bus.out_data  <= 8'h00;
                        bus.out_last  <= 1'b1;
                        bus.out_err   <= 1'b1;
                        timeout_err   <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                // Termination uses out_last (equality before increment), so
                // LAST_ADDR = 8'hFF never wraps to 8'h00.
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.out_last) begin
                            dump_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            addr         <= addr + 8'd1;
                            bus.rd_addr  <= addr + 8'd1;
                            bus.rd_start <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adv7513_reg_dump.sv
// Directed bench for adv7513_reg_dump. dut_a walks 8'h40..8'h43 with a
// 100-cycle timeout, dut_b dumps the single register 8'hFF. Each has a read
// model answering addr^8'hA5 fifty cycles after rd_start.
module tb_adv7513_reg_dump;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
        logic       err;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_data [4] = '{8'hE5, 8'hE4, 8'hE7, 8'hE6};

    // ---------------- dut_a ----------------
    adv7513_reg_dump_if ifa();
    logic a_trig, a_busy_o, a_done_o, a_terr, a_ready, a_inj, a_hang;
    logic a_mdone, a_mbusy;
    logic [7:0] a_mdata, a_maddr;
    int a_mcnt;

    adv7513_reg_dump #(.FIRST_ADDR(8'h40), .LAST_ADDR(8'h43), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .reset(reset), .trigger(a_trig), .busy(a_busy_o),
        .bus(ifa.master), .dump_done(a_done_o), .timeout_err(a_terr)
    );

    assign ifa.rd_done   = a_mdone | a_inj;
    assign ifa.rd_data   = a_inj ? 8'h77 : a_mdata;
    assign ifa.out_ready = a_ready;

    // Read model A: latches the address one cycle after start, answers 50 cycles after start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mbusy <= 1'b0; a_mdone <= 1'b0; a_mdata <= 8'h00; a_mcnt <= 0; a_maddr <= 8'h00;
        end else begin
            a_mdone <= 1'b0;
            if (a_mbusy) begin
                a_mcnt <= a_mcnt + 1;
                if (a_mcnt == 0) a_maddr <= ifa.rd_addr;
                if (a_mcnt == 48) begin
                    a_mbusy <= 1'b0;
                    if (!(a_hang && a_maddr == 8'h42)) begin
                        a_mdone <= 1'b1;
                        a_mdata <= a_maddr ^ 8'hA5;
                    end
                end
            end else if (ifa.rd_start) begin
                a_mbusy <= 1'b1;
                a_mcnt  <= 0;
            end
        end
    end

    beat_t      a_beats[$];
    int         a_acc_cyc[$];
    int         a_start_cyc[$];
    logic [7:0] a_start_addr[$];
    int         a_dones = 0;

    always @(negedge clk) begin
        if (ifa.rd_start) begin
            a_start_cyc.push_back(cyc);
            a_start_addr.push_back(ifa.rd_addr);
        end
        if (ifa.out_valid && ifa.out_ready) begin
            a_beats.push_back(beat_t'({ifa.out_addr, ifa.out_data, ifa.out_last, ifa.out_err}));
            a_acc_cyc.push_back(cyc);
        end
        if (a_done_o) a_dones++;
    end

    // ---------------- dut_b ----------------
    adv7513_reg_dump_if ifb();
    logic b_trig, b_busy_o, b_done_o, b_terr, b_ready;
    logic b_mdone, b_mbusy;
    logic [7:0] b_mdata, b_maddr;
    int b_mcnt;

    adv7513_reg_dump #(.FIRST_ADDR(8'hFF), .LAST_ADDR(8'hFF), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset), .trigger(b_trig), .busy(b_busy_o),
        .bus(ifb.master), .dump_done(b_done_o), .timeout_err(b_terr)
    );

    assign ifb.rd_done   = b_mdone;
    assign ifb.rd_data   = b_mdata;
    assign ifb.out_ready = b_ready;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_mbusy <= 1'b0; b_mdone <= 1'b0; b_mdata <= 8'h00; b_mcnt <= 0; b_maddr <= 8'h00;
        end else begin
            b_mdone <= 1'b0;
            if (b_mbusy) begin
                b_mcnt <= b_mcnt + 1;
                if (b_mcnt == 0) b_maddr <= ifb.rd_addr;
                if (b_mcnt == 48) begin
                    b_mbusy <= 1'b0;
                    b_mdone <= 1'b1;
                    b_mdata <= b_maddr ^ 8'hA5;
                end
            end else if (ifb.rd_start) begin
                b_mbusy <= 1'b1;
                b_mcnt  <= 0;
            end
        end
    end

    beat_t      b_beats[$];
    logic [7:0] b_start_addr[$];
    int         b_dones = 0;

    always @(negedge clk) begin
        if (ifb.rd_start) b_start_addr.push_back(ifb.rd_addr);
        if (ifb.out_valid && ifb.out_ready)
            b_beats.push_back(beat_t'({ifb.out_addr, ifb.out_data, ifb.out_last, ifb.out_err}));
        if (b_done_o) b_dones++;
    end

    // ---------------- helpers (no checks inside) ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_a_trigger();
        @(posedge clk); #1 a_trig = 1'b1;
        @(posedge clk); #1 a_trig = 1'b0;
    endtask

    task automatic wait_a_dones(input int target, input int budget, output bit ok);
        int n = 0;
        while (a_dones < target && n < budget) begin step(); n++; end
        ok = (a_dones >= target);
    endtask

    function automatic beat_t a_beat(input int idx);
        return (idx < a_beats.size()) ? a_beats[idx] : '1;
    endfunction

    function automatic int a_acc(input int idx);
        return (idx < a_acc_cyc.size()) ? a_acc_cyc[idx] : -1000;
    endfunction

    function automatic int a_st(input int idx);
        return (idx < a_start_cyc.size()) ? a_start_cyc[idx] : -1000;
    endfunction

    function automatic logic [30:0] a_outs();
        return {a_busy_o, ifa.rd_start, ifa.rd_addr, ifa.out_valid, ifa.out_addr,
                ifa.out_data, ifa.out_last, ifa.out_err, a_done_o, a_terr};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (a_outs() !== 31'd0) begin
            errors++; $display("FAIL reset_a_outputs: got %h, required 0", a_outs());
        end
        checks++;
        if ({b_busy_o, ifb.rd_start, ifb.rd_addr, ifb.out_valid, ifb.out_addr, ifb.out_data,
             ifb.out_last, ifb.out_err, b_done_o, b_terr} !== 31'd0) begin
            errors++; $display("FAIL reset_b_outputs: dut_b outputs not all zero");
        end
        @(posedge clk); #1 reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int b0 = a_beats.size();
        int s0 = a_start_cyc.size();
        int d0 = a_dones;
        int n = 0;
        beat_t e;
        pulse_a_trigger();
        while (a_done_o !== 1'b1 && n < 1000) begin step(); n++; end
        checks++;
        if (a_done_o !== 1'b1) begin errors++; $display("FAIL basic_done_seen: dump_done=%b, required 1", a_done_o); end
        checks++;
        if (a_busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_with_done: busy=%b, required 1", a_busy_o); end
        step();
        checks++;
        if ({a_busy_o, a_done_o} !== 2'b00) begin
            errors++; $display("FAIL basic_busy_after_done: busy,dump_done=%b, required 00", {a_busy_o, a_done_o});
        end
        checks++;
        if (a_beats.size() - b0 != 4) begin errors++; $display("FAIL basic_beat_count: got %0d, required 4", a_beats.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            e = {8'h40 + 8'(i), exp_data[i], (i == 3), 1'b0};
            checks++;
            if (a_beat(b0 + i) !== e) begin errors++; $display("FAIL basic_beat%0d: got %h, required %h", i, a_beat(b0 + i), e); end
        end
        checks++;
        if (a_dones - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", a_dones - d0); end
        checks++;
        if (a_acc(b0) - a_st(s0) != 51) begin
            errors++; $display("FAIL basic_valid_latency: got %0d cycles, required 51", a_acc(b0) - a_st(s0));
        end
        checks++;
        if (a_st(s0 + 1) - a_acc(b0) != 1) begin
            errors++; $display("FAIL basic_next_start: got %0d cycles, required 1", a_st(s0 + 1) - a_acc(b0));
        end
    endtask

    task automatic test_backpressure();
        int b0 = a_beats.size();
        int d0 = a_dones;
        int n = 0;
        int sc;
        int unstable = 0;
        bit ok;
        beat_t snap, e;
        pulse_a_trigger();
        while (a_beats.size() < b0 + 1 && n < 300) begin step(); n++; end
        @(posedge clk); #1 a_ready = 1'b0;
        n = 0;
        while (ifa.out_valid !== 1'b1 && n < 300) begin step(); n++; end
        snap = {ifa.out_addr, ifa.out_data, ifa.out_last, ifa.out_err};
        sc = a_start_cyc.size();
        repeat (20) begin
            step();
            if ({ifa.out_valid, ifa.out_addr, ifa.out_data, ifa.out_last, ifa.out_err} !== {1'b1, snap}) unstable++;
        end
        checks++;
        if (snap !== beat_t'({8'h41, 8'hE4, 1'b0, 1'b0})) begin errors++; $display("FAIL stall_beat: got %h, required 41e400", snap); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, required 0", unstable); end
        checks++;
        if (a_start_cyc.size() != sc) begin errors++; $display("FAIL stall_no_start: %0d rd_start during stall, required 0", a_start_cyc.size() - sc); end
        @(posedge clk); #1 a_ready = 1'b1;
        wait_a_dones(d0 + 1, 1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done: dump_done count %0d, required %0d", a_dones, d0 + 1); end
        for (int i = 0; i < 4; i++) begin
            e = {8'h40 + 8'(i), exp_data[i], (i == 3), 1'b0};
            checks++;
            if (a_beat(b0 + i) !== e) begin errors++; $display("FAIL stall_beat%0d: got %h, required %h", i, a_beat(b0 + i), e); end
        end
    endtask

    task automatic test_timeout();
        int b0 = a_beats.size();
        int s0 = a_start_cyc.size();
        int d0 = a_dones;
        bit ok;
        beat_t e;
        a_hang = 1'b1;
        pulse_a_trigger();
        wait_a_dones(d0 + 1, 1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_done: dump_done not seen, required 1"); end
        checks++;
        if (a_beats.size() - b0 != 3) begin errors++; $display("FAIL tmo_beat_count: got %0d, required 3", a_beats.size() - b0); end
        for (int i = 0; i < 3; i++) begin
            e = (i == 2) ? beat_t'({8'h42, 8'h00, 1'b1, 1'b1}) : beat_t'({8'h40 + 8'(i), exp_data[i], 1'b0, 1'b0});
            checks++;
            if (a_beat(b0 + i) !== e) begin errors++; $display("FAIL tmo_beat%0d: got %h, required %h", i, a_beat(b0 + i), e); end
        end
        checks++;
        if (a_acc(b0 + 2) - a_st(s0 + 2) != 101) begin
            errors++; $display("FAIL tmo_latency: got %0d cycles, required 101", a_acc(b0 + 2) - a_st(s0 + 2));
        end
        checks++;
        if (a_terr !== 1'b1) begin errors++; $display("FAIL tmo_sticky: timeout_err=%b, required 1", a_terr); end
        repeat (150) step();
        checks++;
        if (a_start_cyc.size() - s0 != 3 || a_busy_o !== 1'b0) begin
            errors++; $display("FAIL tmo_no_more_reads: starts=%0d busy=%b, required 3 and 0", a_start_cyc.size() - s0, a_busy_o);
        end
        a_hang = 1'b0;
        pulse_a_trigger();
        step();
        checks++;
        if (a_terr !== 1'b0) begin errors++; $display("FAIL tmo_clear: timeout_err=%b, required 0", a_terr); end
        wait_a_dones(d0 + 2, 1000, ok);
        checks++;
        if (!ok || a_beats.size() - b0 != 7) begin
            errors++; $display("FAIL tmo_rerun: beats=%0d, required 7", a_beats.size() - b0);
        end
    endtask

    task automatic test_single();
        int b0 = b_beats.size();
        int s0 = b_start_addr.size();
        int d0 = b_dones;
        int n = 0;
        @(posedge clk); #1 b_trig = 1'b1;
        @(posedge clk); #1 b_trig = 1'b0;
        while (b_dones == d0 && n < 500) begin step(); n++; end
        repeat (100) step();
        checks++;
        if (b_beats.size() - b0 != 1 || b_dones - d0 != 1) begin
            errors++; $display("FAIL single_count: beats=%0d dones=%0d, required 1 and 1", b_beats.size() - b0, b_dones - d0);
        end
        checks++;
        if (b_beats.size() > b0 && b_beats[b0] !== beat_t'({8'hFF, 8'h5A, 1'b1, 1'b0})) begin
            errors++; $display("FAIL single_beat: got %h, required ff5a2", b_beats[b0]);
        end
        checks++;
        if (b_start_addr.size() - s0 != 1 || b_busy_o !== 1'b0) begin
            errors++; $display("FAIL single_no_wrap: reads=%0d busy=%b, required 1 and 0", b_start_addr.size() - s0, b_busy_o);
        end
    endtask

    task automatic test_ignored();
        int b0 = a_beats.size();
        int s0 = a_start_cyc.size();
        int d0 = a_dones;
        int n = 0;
        bit ok;
        beat_t e;
        pulse_a_trigger();
        while (a_beats.size() < b0 + 1 && n < 300) begin step(); n++; end
        @(posedge clk); #1 a_ready = 1'b0;
        pulse_a_trigger();
        n = 0;
        while (ifa.out_valid !== 1'b1 && n < 300) begin step(); n++; end
        @(posedge clk); #1 a_inj = 1'b1;
        @(posedge clk); #1 a_inj = 1'b0;
        step();
        checks++;
        if ({ifa.out_valid, ifa.out_addr, ifa.out_data} !== {1'b1, 8'h41, 8'hE4}) begin
            errors++; $display("FAIL ign_emit_done: valid,addr,data=%h, required 141e4", {ifa.out_valid, ifa.out_addr, ifa.out_data});
        end
        checks++;
        if (a_start_cyc.size() - s0 != 2) begin errors++; $display("FAIL ign_emit_starts: got %0d, required 2", a_start_cyc.size() - s0); end
        @(posedge clk); #1 a_ready = 1'b1;
        wait_a_dones(d0 + 1, 1000, ok);
        repeat (80) step();
        for (int i = 0; i < 4; i++) begin
            e = {8'h40 + 8'(i), exp_data[i], (i == 3), 1'b0};
            checks++;
            if (a_beat(b0 + i) !== e) begin errors++; $display("FAIL ign_beat%0d: got %h, required %h", i, a_beat(b0 + i), e); end
        end
        checks++;
        if (a_beats.size() - b0 != 4 || a_dones - d0 != 1 || a_start_cyc.size() - s0 != 4 || a_busy_o !== 1'b0) begin
            errors++; $display("FAIL ign_totals: beats=%0d dones=%0d starts=%0d busy=%b, required 4 1 4 0",
                               a_beats.size() - b0, a_dones - d0, a_start_cyc.size() - s0, a_busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int s0 = a_start_cyc.size();
        int d0 = a_dones;
        int b1, s1;
        int n = 0;
        bit ok;
        pulse_a_trigger();
        while (a_start_cyc.size() < s0 + 2 && n < 300) begin step(); n++; end
        repeat (10) step();
        checks++;
        if ({a_busy_o, ifa.rd_addr, ifa.out_valid} !== {1'b1, 8'h41, 1'b0}) begin
            errors++; $display("FAIL rst_pre_wait: busy,rd_addr,valid=%h, required 1410", {a_busy_o, ifa.rd_addr, ifa.out_valid});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (a_outs() !== 31'd0) begin errors++; $display("FAIL rst_async_zero: got %h, required 0", a_outs()); end
        repeat (3) step();
        @(posedge clk); #1 reset = 1'b1;
        repeat (60) step();
        checks++;
        if (a_dones != d0 || a_busy_o !== 1'b0) begin
            errors++; $display("FAIL rst_no_done: dones=%0d busy=%b, required %0d and 0", a_dones, a_busy_o, d0);
        end
        b1 = a_beats.size();
        s1 = a_start_cyc.size();
        pulse_a_trigger();
        wait_a_dones(d0 + 1, 1000, ok);
        step();
        checks++;
        if (!ok || a_beats.size() - b1 != 4) begin errors++; $display("FAIL rst_rerun_count: beats=%0d, required 4", a_beats.size() - b1); end
        checks++;
        if (s1 >= a_start_addr.size() || a_start_addr[s1] !== 8'h40 || a_beat(b1) !== beat_t'({8'h40, 8'hE5, 1'b0, 1'b0})) begin
            errors++; $display("FAIL rst_restart_first: beat %h, required 40e500", a_beat(b1));
        end
    endtask

    initial begin
        reset  = 1'b0;
        a_trig = 1'b0; a_ready = 1'b1; a_inj = 1'b0; a_hang = 1'b0;
        b_trig = 1'b0; b_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_single();
        test_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adv7513_reg_dump.md
Name: adv7513_reg_dump

Overview:
- Sequencer upstream of the ADV7513 single-register read block.
- Walks a contiguous register address range and issues one read per address using a start/done handshake.
- Streams each (address, data) pair out on a valid/ready interface, for a UART or debug logger downstream.
- Guards every read with a timeout, so a hung I2C transaction aborts the dump instead of stalling it.

Parameters:
- FIRST_ADDR, 8'h00, first register address read.
- LAST_ADDR, 8'hFF, last register address read (inclusive); must be >= FIRST_ADDR.
- TIMEOUT_CYCLES, 200000, max clk cycles from rd_start to rd_done before abort; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- trigger  input  1  start a dump; sampled only in IDLE
- busy  output  1  high in any state other than IDLE
- rd_start  output  1  one-cycle start pulse to the register read block
- rd_addr  output  8  register address to the read block
- rd_done  input  1  one-cycle completion pulse from the read block
- rd_data  input  8  read data; valid in the cycle rd_done is high
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_addr  output  8  register address of the beat
- out_data  output  8  register value of the beat
- out_last  output  1  final beat of the dump
- out_err  output  1  beat produced by a timeout; out_data is 8'h00
- dump_done  output  1  one-cycle pulse after the final beat is accepted
- timeout_err  output  1  sticky; set on timeout, cleared on the next accepted trigger

Behaviour:
- Reset: all outputs 0, state IDLE, address counter = FIRST_ADDR, timeout counter = 0.
- State IDLE:
  - trigger=1 -> ISSUE; address counter loads FIRST_ADDR; timeout_err clears.
- State ISSUE (1 cycle):
  - rd_start=1; timeout counter clears; next state WAIT.
- State WAIT:
  - rd_done=1 -> capture rd_data into out_data, address into out_addr; out_err=0; out_last = (addr==LAST_ADDR); go to EMIT.
  - Timeout counter reaches TIMEOUT_CYCLES without rd_done -> out_data=8'h00, out_err=1, out_last=1; set timeout_err; go to EMIT.
  - If rd_done and the timeout both occur in the same cycle, rd_done wins.
- State EMIT:
  - out_valid=1; out_addr, out_data, out_last and out_err stay stable until out_ready=1.
  - On accept with out_last=0: increment the address, go to ISSUE.
  - On accept with out_last=1: pulse dump_done, go to IDLE.
- out_valid rises the cycle after rd_done or the timeout. Under continuous out_ready, the next rd_start follows the accept by 1 cycle.
- rd_addr equals the address counter and is held stable from the rd_start cycle through rd_done. The read block flops its address input, so it samples the address one cycle after start.
- No rd_start is issued while a beat is unaccepted; downstream backpressure stalls the reads.
- LAST_ADDR=8'hFF terminates on equality compare before increment and never wraps to 8'h00. FIRST_ADDR==LAST_ADDR yields exactly one beat.
- trigger while busy=1 is ignored; no queuing.
- A timeout always ends the dump; no further reads are issued. The read block may still be busy after a timeout.
- rd_done received outside WAIT is ignored.
- reset asserted mid-dump returns the block to IDLE immediately. Any in-flight beat is dropped and no dump_done pulse is produced.

Test Plan:
- FIRST_ADDR=8'h40, LAST_ADDR=8'h43, read model returns addr^8'hA5 after 50 cycles, out_ready=1 -> 4 beats (40,E5)(41,E4)(42,E7)(43,E6); out_last only on 43; one dump_done; busy falls the cycle after dump_done.
- Same range, out_ready held low 20 cycles on beat 2 -> beat stays stable and no rd_start during the stall; sequence and data unchanged.
- Read model never returns rd_done on addr 8'h42, TIMEOUT_CYCLES=100 -> beat (42,00) with out_err=1 and out_last=1 exactly 101 cycles after its rd_start; timeout_err=1; no further rd_start; a new trigger clears timeout_err.
- FIRST_ADDR=LAST_ADDR=8'hFF -> exactly one beat, addr FF, out_last=1; no read of 8'h00.
- trigger pulsed again mid-dump, and rd_done injected during EMIT -> both ignored; beat count and values unchanged.
- reset asserted low during WAIT of addr 8'h41 -> all outputs 0 asynchronously; after release and a new trigger, the dump restarts from FIRST_ADDR.
